// File: rtl/frame_clearer.sv
// Frame clear engine: sweeps every pixel in raster order and writes CLEAR_COLOR through a valid/ready port.
// Optional depth-buffer clear in parallel when FRAME_CLEARER_DEPTH_EN is defined.
module frame_clearer #(
   parameter int                 H_RES       = 640,
   parameter int                 V_RES       = 480,
   parameter int                 ADDR_W      = 19,
   parameter int                 PIXEL_W     = 16,
   parameter logic [PIXEL_W-1:0] CLEAR_COLOR = '0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               clear_start,
   output logic               clear_done,
   output logic [9:0]         clear_DrawX,
   output logic [9:0]         clear_DrawY,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [PIXEL_W-1:0] wr_data
`ifdef FRAME_CLEARER_DEPTH_EN
   ,
   output logic               z_wr_valid,
   input  logic               z_wr_ready,
   output logic [ADDR_W-1:0]  z_wr_addr,
   output logic [15:0]        z_wr_data
`endif
);

   localparam logic [9:0]        X_LAST   = 10'(H_RES - 1);
   localparam logic [9:0]        Y_LAST   = 10'(V_RES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   if ((2 ** ADDR_W) < (H_RES * V_RES)) begin : g_addr_check
      $error("frame_clearer: ADDR_W too small for H_RES*V_RES");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SWEEP,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [9:0]        r_x;
   logic [9:0]        r_y;
   logic [ADDR_W-1:0] r_addr;

   logic w_live;
   logic w_last;
   logic w_adv;

   // A sweep is only live while the request is still held; dropping it kills valid in the same cycle.
   assign w_live = (r_state == S_SWEEP) && clear_start;
   assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

`ifdef FRAME_CLEARER_DEPTH_EN
   logic r_c_acc;
   logic r_z_acc;
   logic w_c_set;
   logic w_z_set;

   assign wr_valid   = w_live && !r_c_acc;
   assign z_wr_valid = w_live && !r_z_acc;
   assign w_c_set    = r_c_acc | (wr_valid & wr_ready);
   assign w_z_set    = r_z_acc | (z_wr_valid & z_wr_ready);
   assign w_adv      = w_live && w_c_set && w_z_set;
   assign z_wr_addr  = r_addr;
   assign z_wr_data  = 16'hFFFF;

   // Per-pixel accepted flags; cleared whenever the pixel advances or the sweep stops.
   always_ff @(posedge Clk) begin
      if (Reset || !w_live || w_adv) begin
         r_c_acc <= 1'b0;
         r_z_acc <= 1'b0;
      end else begin
         r_c_acc <= w_c_set;
         r_z_acc <= w_z_set;
      end
   end
`else
   assign wr_valid = w_live;
   assign w_adv    = wr_valid & wr_ready;
`endif

   assign wr_addr     = r_addr;
   assign wr_data     = CLEAR_COLOR;
   assign clear_DrawX = r_x;
   assign clear_DrawY = r_y;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Abort takes priority over a transfer advance.
   always_comb begin
      w_state_nxt = r_state;
      clear_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (clear_start) w_state_nxt = S_SWEEP;
         end
         S_SWEEP: begin
            if (!clear_start)          w_state_nxt = S_IDLE;
            else if (w_adv && w_last)  w_state_nxt = S_DONE;
         end
         S_DONE: begin
            clear_done = 1'b1;
            if (!clear_start) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Position counters; addr tracks y*H_RES+x incrementally and holds on the last pixel into DONE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else begin
         unique case (r_state)
            S_SWEEP: begin
               if (!clear_start) begin
                  r_x    <= '0;
                  r_y    <= '0;
                  r_addr <= '0;
               end else if (w_adv && !w_last) begin
                  if (r_x == X_LAST) begin
                     r_x <= '0;
                     r_y <= r_y + 10'd1;
                  end else begin
                     r_x <= r_x + 10'd1;
                  end
                  r_addr <= r_addr + ADDR_ONE;
               end
            end
            S_DONE: begin
               if (!clear_start) begin
                  r_x    <= '0;
                  r_y    <= '0;
                  r_addr <= '0;
               end
            end
            default: begin
               r_x    <= '0;
               r_y    <= '0;
               r_addr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_clearer.sv
// Bench for frame_clearer on a 4x3 frame: randomized/directed ready patterns checked against a pixel-index model.
module tb_frame_clearer;
   localparam int H = 4;
   localparam int V = 3;
   localparam int N = H * V;
   localparam int AW = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        clear_start = 1'b0;
   logic        clear_done;
   logic [9:0]  clear_DrawX, clear_DrawY;
   logic        wr_valid;
   logic        wr_ready = 1'b0;
   logic [AW-1:0] wr_addr;
   logic [15:0] wr_data;
`ifdef FRAME_CLEARER_DEPTH_EN
   logic          z_wr_valid;
   logic          z_wr_ready = 1'b0;
   logic [AW-1:0] z_wr_addr;
   logic [15:0]   z_wr_data;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int dcyc;

   frame_clearer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .PIXEL_W(16), .CLEAR_COLOR(16'hABCD)) dut (
      .Clk(Clk), .Reset(Reset), .clear_start(clear_start), .clear_done(clear_done),
      .clear_DrawX(clear_DrawX), .clear_DrawY(clear_DrawY),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef FRAME_CLEARER_DEPTH_EN
      , .z_wr_valid(z_wr_valid), .z_wr_ready(z_wr_ready), .z_wr_addr(z_wr_addr), .z_wr_data(z_wr_data)
`endif
   );

   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_begin();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_valid"}, 32'(wr_valid), 0);
      chk({tag, "_done"}, 32'(clear_done), 0);
      chk({tag, "_x"}, 32'(clear_DrawX), 0);
      chk({tag, "_y"}, 32'(clear_DrawY), 0);
      chk({tag, "_addr"}, 32'(wr_addr), 0);
`ifdef FRAME_CLEARER_DEPTH_EN
      chk({tag, "_zvalid"}, 32'(z_wr_valid), 0);
`endif
   endtask

   // rmode: 0 ready=1, 1 ready pattern 1,0,0, 2 random. zmode: 0 ready=1, 1 pulse every 3rd cycle.
   // Called at posedge+1 with DUT idle; ends at posedge+1 after the done/abort/reset cycle.
   task automatic run_sweep(input int rmode, input int zmode, input int abort_at,
                            input int reset_at, output int done_cyc);
      int  p = 0;
      bit  fin = 0;
      bit  live, ev, xc, adv;
`ifdef FRAME_CLEARER_DEPTH_EN
      bit  cacc = 0, zacc = 0, ezv, xz;
`endif
      done_cyc = -1;
      clear_start = 1'b1;
      settle();
      idle_check("start");
      cyc_begin();
      for (int c = 1; c < 300 && !fin; c++) begin
         case (rmode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ((c - 1) % 3 == 0);
            default: wr_ready = 1'($urandom_range(0, 1));
         endcase
`ifdef FRAME_CLEARER_DEPTH_EN
         z_wr_ready = (zmode == 0) ? 1'b1 : (c % 3 == 0);
`endif
         if (abort_at >= 0 && p == abort_at) clear_start = 1'b0;
         if (reset_at >= 0 && p == reset_at) Reset = 1'b1;
         settle();
         if (p == N) begin
            chk("done_flag", 32'(clear_done), 1);
            chk("done_valid", 32'(wr_valid), 0);
            chk("done_x", 32'(clear_DrawX), H - 1);
            chk("done_y", 32'(clear_DrawY), V - 1);
`ifdef FRAME_CLEARER_DEPTH_EN
            chk("done_zvalid", 32'(z_wr_valid), 0);
`endif
            done_cyc = c;
            fin = 1;
            adv = 0;
         end else begin
            live = clear_start;
            ev = live;
`ifdef FRAME_CLEARER_DEPTH_EN
            ev  = live && !cacc;
            ezv = live && !zacc;
            chk("zvalid", 32'(z_wr_valid), 32'(ezv));
            if (ezv) begin
               chk("zaddr", 32'(z_wr_addr), p);
               chk("zdata", 32'(z_wr_data), 32'hFFFF);
            end
`endif
            chk("valid", 32'(wr_valid), 32'(ev));
            chk("busy_done", 32'(clear_done), 0);
            if (live) begin
               chk("addr", 32'(wr_addr), p);
               chk("x", 32'(clear_DrawX), p % H);
               chk("y", 32'(clear_DrawY), p / H);
               chk("data", 32'(wr_data), 32'hABCD);
            end
            xc = ev && wr_ready;
            adv = xc;
`ifdef FRAME_CLEARER_DEPTH_EN
            xz  = ezv && z_wr_ready;
            adv = live && (cacc || xc) && (zacc || xz);
`endif
            if (!live || Reset) fin = 1;
         end
         cyc_begin();
         if (!fin && adv) p++;
`ifdef FRAME_CLEARER_DEPTH_EN
         if (adv) begin
            cacc = 0;
            zacc = 0;
         end else begin
            cacc = cacc || xc;
            zacc = zacc || xz;
         end
`endif
      end
      if (!fin) chk("sweep_timeout", 0, 1);
   endtask

   initial begin
      // reset state
      repeat (3) cyc_begin();
      settle();
      idle_check("reset");
      Reset = 1'b0;
      cyc_begin();
      settle();
      idle_check("post_reset");
      cyc_begin();

      // full sweep, ready tied high: done 13 cycles after start is sampled
      run_sweep(0, 0, -1, -1, dcyc);
      chk("done_latency", dcyc, N + 1);
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("hold_done", 32'(clear_done), 1);
         chk("hold_valid", 32'(wr_valid), 0);
         cyc_begin();
      end
      clear_start = 1'b0;
      cyc_begin();
      settle();
      idle_check("drop_done");
      cyc_begin();

      // second identical request
      run_sweep(0, 0, -1, -1, dcyc);
      chk("done_latency2", dcyc, N + 1);
      clear_start = 1'b0;
      cyc_begin();
      cyc_begin();

      // stalled sweep with ready 1,0,0 pattern
      run_sweep(1, 0, -1, -1, dcyc);
      chk("stall_done_seen", 32'(dcyc > 0), 1);
      clear_start = 1'b0;
      cyc_begin();
      cyc_begin();

      // abort after 5 transfers, then restart with random ready
      run_sweep(0, 0, 5, -1, dcyc);
      chk("abort_no_done", 32'(dcyc), 32'hFFFFFFFF);
      for (int k = 0; k < 3; k++) begin
         settle();
         idle_check("abort_idle");
         cyc_begin();
      end
      run_sweep(2, 0, -1, -1, dcyc);
      chk("restart_done_seen", 32'(dcyc > 0), 1);
      clear_start = 1'b0;
      cyc_begin();
      cyc_begin();

      // reset at transfer 7 with clear_start held; restart from (0,0)
      run_sweep(0, 0, -1, 7, dcyc);
      Reset = 1'b0;
      run_sweep(0, 0, -1, -1, dcyc);
      chk("after_reset_latency", dcyc, N + 1);
      clear_start = 1'b0;
      cyc_begin();
      cyc_begin();

`ifdef FRAME_CLEARER_DEPTH_EN
      // depth channel throttled to every third cycle
      run_sweep(0, 1, -1, -1, dcyc);
      chk("depth_done_seen", 32'(dcyc > N + 1), 1);
      clear_start = 1'b0;
      cyc_begin();
      cyc_begin();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
